// File: rtl/myproject_mul_rr_arb.sv
// Round-robin arbiter feeding one shared 2-stage signed multiplier pipeline.
// Optional statistics counters are enabled by defining MUL_RR_ARB_STATS_EN.
module myproject_mul_rr_arb #(
  parameter int N_REQ      = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 29,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*DIN_WIDTH-1:0]   req_a,
  input  logic [N_REQ*DIN_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic [DOUT_WIDTH-1:0]        rsp_data
`ifdef MUL_RR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]          grant_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  logic                  stall_s;
  logic                  grant_any_s;
  logic [IDW-1:0]        grant_idx_s;
  logic                  xfer_s;
  logic [IDW-1:0]        ptr_r;
  logic [IDW-1:0]        ptr_nxt_s;
  logic [DIN_WIDTH-1:0]  sel_a_s;
  logic [DIN_WIDTH-1:0]  sel_b_s;
  logic                  s1_valid_r;
  logic [IDW-1:0]        s1_id_r;
  logic [DIN_WIDTH-1:0]  s1_a_r;
  logic [DIN_WIDTH-1:0]  s1_b_r;
  logic [DOUT_WIDTH-1:0] a_ext_s;
  logic [DOUT_WIDTH-1:0] b_ext_s;
  logic [DOUT_WIDTH-1:0] prod_s;

  assign stall_s = rsp_valid & ~rsp_ready;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    int idx;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!grant_any_s && req_valid[idx]) begin
        grant_any_s = 1'b1;
        grant_idx_s = IDW'(idx);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Grant is withheld during reset and while the output is back-pressured.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && !stall_s && grant_any_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer_s  = |(req_valid & req_ready);
  assign sel_a_s = req_a[grant_idx_s*DIN_WIDTH +: DIN_WIDTH];
  assign sel_b_s = req_b[grant_idx_s*DIN_WIDTH +: DIN_WIDTH];

  // Pointer moves just past the granted requester.
  always_comb begin
    if (int'(grant_idx_s) == N_REQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_idx_s + 1'b1;
    end
  end

  // Low DOUT_WIDTH bits of a product depend only on the low DOUT_WIDTH operand bits.
  generate
    if (DOUT_WIDTH > DIN_WIDTH) begin : g_ext
      assign a_ext_s = {{(DOUT_WIDTH-DIN_WIDTH){s1_a_r[DIN_WIDTH-1]}}, s1_a_r};
      assign b_ext_s = {{(DOUT_WIDTH-DIN_WIDTH){s1_b_r[DIN_WIDTH-1]}}, s1_b_r};
    end else begin : g_trunc
      assign a_ext_s = s1_a_r[DOUT_WIDTH-1:0];
      assign b_ext_s = s1_b_r[DOUT_WIDTH-1:0];
    end
  endgenerate

  assign prod_s = a_ext_s * b_ext_s;

  // Arbitration pointer and stage 1 (operands, id, valid).
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_id_r    <= '0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
    end else if (!stall_s) begin
      if (xfer_s) begin
        ptr_r <= ptr_nxt_s;
      end
      s1_valid_r <= xfer_s;
      s1_id_r    <= grant_idx_s;
      s1_a_r     <= sel_a_s;
      s1_b_r     <= sel_b_s;
    end
  end

  // Stage 2 drives the response outputs directly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (!stall_s) begin
      rsp_valid <= s1_valid_r;
      rsp_id    <= s1_id_r;
      rsp_data  <= prod_s;
    end
  end

`ifdef MUL_RR_ARB_STATS_EN
  // Wrapping per-requester transfer counters and stall-cycle counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= 16'd0;
    end else begin
      if (xfer_s) begin
        grant_cnt[grant_idx_s*16 +: 16] <= grant_cnt[grant_idx_s*16 +: 16] + 16'd1;
      end
      if (stall_s) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_myproject_mul_rr_arb.sv
// Self-checking bench for myproject_mul_rr_arb: directed scenarios plus random
// traffic checked against a cycle-level behavioural model of the arbiter/pipeline.
module tb_myproject_mul_rr_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 29;

  logic            ap_clk;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [OW-1:0]   rsp_data;
`ifdef MUL_RR_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  myproject_mul_rr_arb #(.N_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef MUL_RR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: in-flight operations in issue order, plus the round-robin pointer.
  typedef struct {
    logic          v;
    int            id;
    logic [OW-1:0] d;
  } op_t;
  op_t m1, m2;
  int  m_ptr;
  int  grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_prod(input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return p[OW-1:0];
  endfunction

  task automatic model_clear();
    m1.v = 1'b0; m1.id = 0; m1.d = '0;
    m2.v = 1'b0; m2.id = 0; m2.d = '0;
    m_ptr = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit            stall;
    int            g;
    int            idx;
    logic [N-1:0]  exp_rdy;
    logic [OW-1:0] nd;
    #1;
    stall = m2.v && !rsp_ready;
    g = -1;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m2.v));
    if (m2.v) begin
      chk("rsp_id", 32'(rsp_id), 32'(m2.id));
      chk("rsp_data", 32'(rsp_data), 32'(m2.d));
    end
    nd = '0;
    if (g >= 0) begin
      nd = ref_prod(req_a[g*DW +: DW], req_b[g*DW +: DW]);
      grant_log.push_back(g);
    end
    @(posedge ap_clk);
    if (!stall) begin
      if (g >= 0) m_ptr = (g + 1) % N;
      m2 = m1;
      m1.v = (g >= 0);
      m1.id = (g >= 0) ? g : 0;
      m1.d = nd;
    end
    @(negedge ap_clk);
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
  endtask

  task automatic do_reset(input logic [N-1:0] rv_during);
    req_valid = rv_during;
    ap_rst_n  = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    model_clear();
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    int exp_order[6];
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_clear();
    @(negedge ap_clk);
    do_reset(4'b1111);

    // Single request: 3 * -5 on requester 0.
    req_valid = 4'b0001;
    set_op(0, 16'd3, 16'hFFFB);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_data", 32'(rsp_data), 32'(29'h1FFFFFF1));
    tick();
    tick();

    // All requesting, pointer from 0: grant order 0,1,2,3,0,1.
    do_reset(4'b0000);
    grant_log.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    exp_order = '{0, 1, 2, 3, 0, 1};
    chk("order_len", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Operand extremes.
    req_valid = 4'b0001;
    set_op(0, 16'h8000, 16'h8000);
    tick();
    set_op(0, 16'h8000, 16'h7FFF);
    tick();
    chk("ext_min_min", 32'(rsp_data), 32'd0);
    req_valid = 4'b0000;
    tick();
    chk("ext_min_max", 32'(rsp_data), 32'(29'h0008000));
    tick();

    // Backpressure with a full pipeline.
    do_reset(4'b0000);
    req_valid = 4'b1111;
    rand_ops();
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`ifdef MUL_RR_ARB_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) tick();

    // Reset with two operations in flight.
    req_valid = 4'b1111;
    rand_ops();
    tick();
    tick();
    do_reset(4'b1111);
    req_valid = 4'b0110;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'(4'b0010));
    chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // Sparse requests: id 2, idle, then id 1 after wrap.
    grant_log.delete();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("sparse_cnt", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("sparse_first", 32'(grant_log[0]), 32'd2);
      chk("sparse_second", 32'(grant_log[1]), 32'd1);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
